// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_pkg
// Purpose  : Shared states, light codes and phase-duration helper for the
//            timed traffic light controller.
// Revision : 1.0
// ============================================================================
package tl_pkg;

    typedef enum logic [2:0] {
        ST_GR    = 3'd0,
        ST_YR    = 3'd1,
        ST_RR1   = 3'd2,
        ST_RG    = 3'd3,
        ST_RY    = 3'd4,
        ST_RR2   = 3'd5,
        ST_PED   = 3'd6,
        ST_FLASH = 3'd7
    } tl_state_e;

    // Light vectors are {G,Y,R}
    localparam logic [2:0] LT_G   = 3'b100;
    localparam logic [2:0] LT_Y   = 3'b010;
    localparam logic [2:0] LT_R   = 3'b001;
    localparam logic [2:0] LT_OFF = 3'b000;

    // FLASH is untimed; returning 1 makes its load value a harmless zero.
    function automatic int unsigned dur_of(
        input tl_state_e   st,
        input int unsigned t_main_g,
        input int unsigned t_side_g,
        input int unsigned t_yel,
        input int unsigned t_allred,
        input int unsigned t_ped
    );
        int unsigned d;
        case (st)
            ST_GR:          d = t_main_g;
            ST_YR, ST_RY:   d = t_yel;
            ST_RR1, ST_RR2: d = t_allred;
            ST_RG:          d = t_side_g;
            ST_PED:         d = t_ped;
            default:        d = 32'd1;
        endcase
        return d;
    endfunction

    function automatic bit dur_ok(input int unsigned t, input int unsigned w);
        return (t >= 32'd1) && (64'(t) <= (64'd1 << w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tl_phase_timer
// Purpose  : Loadable down-counter advanced by the time-base strobe; flags the
//            tick on which the current phase expires.
// Revision : 1.0
// ============================================================================
module tl_phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == '0) && tick;

endmodule
`default_nettype wire

// File: rtl/traffic_light_timed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_timed_ctrl
// Purpose  : Two-street traffic light with per-phase tick timing, pedestrian
//            request latch and night flash. Define PED_COUNTDOWN_EN to add the
//            ped_count output and a blinking walk signal near phase end.
// Revision : 1.0
// ============================================================================
module traffic_light_timed_ctrl
    import tl_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int T_MAIN_G = 20,
    parameter int T_SIDE_G = 12,
    parameter int T_YEL    = 4,
    parameter int T_ALLRED = 2,
    parameter int T_PED    = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             ped_req,
    input  logic             flash_mode,
    output logic [2:0]       main_lights,
    output logic [2:0]       side_lights,
    output logic             ped_walk,
    output logic             ped_pending,
`ifdef PED_COUNTDOWN_EN
    output logic [CNT_W-1:0] ped_count,
`endif
    output logic [2:0]       state_o
);

    if (!dur_ok(T_MAIN_G, CNT_W) || !dur_ok(T_SIDE_G, CNT_W) || !dur_ok(T_YEL, CNT_W) ||
        !dur_ok(T_ALLRED, CNT_W) || !dur_ok(T_PED, CNT_W)) begin : g_bad_duration
        $error("traffic_light_timed_ctrl: every T_* must lie in 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] TMR_RST = CNT_W'(T_MAIN_G - 1);

    tl_state_e        state_q;
    tl_state_e        state_d;
    logic             flash_on_q;
    logic             flash_on_d;
    logic             ped_pending_q;
    logic             ped_pending_d;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic [CNT_W-1:0] timer_cnt;
    logic             timer_done;

    tl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .tick     (tick),
        .cnt      (timer_cnt),
        .done     (timer_done)
    );

    always_comb begin
        state_d       = state_q;
        flash_on_d    = 1'b1;
        ped_pending_d = ped_pending_q;

        case (state_q)
            ST_GR:  if (timer_done) state_d = ST_YR;
            ST_YR:  if (timer_done) state_d = ST_RR1;
            ST_RR1: if (timer_done) state_d = ST_RG;
            ST_RG:  if (timer_done) state_d = ST_RY;
            ST_RY:  if (timer_done) state_d = ST_RR2;
            ST_RR2: begin
                if (timer_done) begin
                    if (flash_mode)         state_d = ST_FLASH;
                    else if (ped_pending_q) state_d = ST_PED;
                    else                    state_d = ST_GR;
                end
            end
            ST_PED: if (timer_done) state_d = ST_GR;
            ST_FLASH: begin
                // Flash ignores the timer; only the strobe and the mode bit matter.
                flash_on_d = flash_on_q;
                if (tick) begin
                    if (!flash_mode) state_d    = ST_RR2;
                    else             flash_on_d = ~flash_on_q;
                end
            end
            default: state_d = ST_GR;
        endcase

        // Entering PED serves the request even if the button is still held.
        if ((state_d == ST_PED) && (state_q != ST_PED)) begin
            ped_pending_d = 1'b0;
        end else if ((state_q != ST_PED) && ped_req) begin
            ped_pending_d = 1'b1;
        end

        timer_load     = (state_d != state_q);
        timer_load_val = CNT_W'(dur_of(state_d, T_MAIN_G, T_SIDE_G, T_YEL, T_ALLRED, T_PED) - 32'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_GR;
            flash_on_q    <= 1'b1;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flash_on_q    <= flash_on_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        main_lights = LT_R;
        side_lights = LT_R;
        case (state_q)
            ST_GR:    main_lights = LT_G;
            ST_YR:    main_lights = LT_Y;
            ST_RG:    side_lights = LT_G;
            ST_RY:    side_lights = LT_Y;
            ST_FLASH: begin
                main_lights = flash_on_q ? LT_Y : LT_OFF;
                side_lights = flash_on_q ? LT_R : LT_OFF;
            end
            default: begin
                main_lights = LT_R;
                side_lights = LT_R;
            end
        endcase
    end

`ifdef PED_COUNTDOWN_EN
    // Remaining-tick parity gives a walk signal that toggles on every tick
    // once two or fewer ticks remain.
    always_comb begin
        ped_count = '0;
        ped_walk  = 1'b0;
        if (state_q == ST_PED) begin
            ped_count = timer_cnt + 1'b1;
            ped_walk  = (ped_count > CNT_W'(2)) || !ped_count[0];
        end
    end
`else
    logic unused_timer_cnt;
    assign unused_timer_cnt = ^timer_cnt;
    assign ped_walk         = (state_q == ST_PED);
`endif

    assign ped_pending = ped_pending_q;
    assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_timed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_timed_ctrl
// Purpose  : Directed and randomized bench with a phase/remaining-ticks model.
// Revision : 1.0
// ============================================================================
module tb_traffic_light_timed_ctrl;

    localparam int CNT_W = 8;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       ped_req;
    logic       flash_mode;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       ped_walk;
    logic       ped_pending;
    logic [2:0] state_o;
`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] ped_count;
`endif

    int errors = 0;
    int checks = 0;
    int tick_mode = 0;
    int div = 0;

    traffic_light_timed_ctrl #(
        .CNT_W    (CNT_W),
        .T_MAIN_G (3),
        .T_SIDE_G (2),
        .T_YEL    (1),
        .T_ALLRED (1),
        .T_PED    (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .ped_req     (ped_req),
        .flash_mode  (flash_mode),
        .main_lights (main_lights),
        .side_lights (side_lights),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending),
`ifdef PED_COUNTDOWN_EN
        .ped_count   (ped_count),
`endif
        .state_o     (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: phase + ticks remaining ----------------
    int m_state;
    int m_rem;
    bit m_pend;
    bit m_fon;

    function automatic int dur(input int s);
        case (s)
            0: return 3;
            1: return 1;
            2: return 1;
            3: return 2;
            4: return 1;
            5: return 1;
            6: return 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int nxt;
        if (!reset_n) begin
            m_state = 0;
            m_rem   = 3;
            m_pend  = 1'b0;
            m_fon   = 1'b1;
        end else begin
            nxt = m_state;
            if (tick) begin
                if (m_state == 7) begin
                    if (!flash_mode) nxt = 5;
                    else             m_fon = !m_fon;
                end else if (m_rem == 1) begin
                    if (m_state == 5)      nxt = flash_mode ? 7 : (m_pend ? 6 : 0);
                    else if (m_state == 6) nxt = 0;
                    else                   nxt = m_state + 1;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
            if (nxt == 6 && m_state != 6)      m_pend = 1'b0;
            else if (m_state != 6 && ped_req)  m_pend = 1'b1;
            if (nxt != m_state) begin
                m_rem = dur(nxt);
                m_fon = 1'b1;
            end
            m_state = nxt;
        end
    end

    function automatic int exp_main(input int s, input bit fon);
        case (s)
            0: return 3'b100;
            1: return 3'b010;
            7: return fon ? 3'b010 : 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    function automatic int exp_side(input int s, input bit fon);
        case (s)
            3: return 3'b100;
            4: return 3'b010;
            7: return fon ? 3'b001 : 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    function automatic int exp_walk(input int s, input int rem);
`ifdef PED_COUNTDOWN_EN
        return int'((s == 6) && (rem > 2 || (rem % 2) == 0));
`else
        return int'((s == 6) && (rem > 0));
`endif
    endfunction

    always @(negedge clk) begin : compare
        bit main_go;
        bit side_go;
        chk("state_o", int'(state_o), m_state);
        chk("main_lights", int'(main_lights), exp_main(m_state, m_fon));
        chk("side_lights", int'(side_lights), exp_side(m_state, m_fon));
        chk("ped_walk", int'(ped_walk), exp_walk(m_state, m_rem));
        chk("ped_pending", int'(ped_pending), int'(m_pend));
`ifdef PED_COUNTDOWN_EN
        chk("ped_count", int'(ped_count), (m_state == 6) ? m_rem : 0);
`endif
        main_go = (main_lights != 3'b001) && (main_lights != 3'b000);
        side_go = (side_lights != 3'b001) && (side_lights != 3'b000);
        chk("one_street_go", int'(main_go && side_go), 0);
    end

    // ---------------- tick generator ----------------
    always @(negedge clk) begin
        case (tick_mode)
            0: tick = 1'b1;
            1: begin
                tick = (div == 2);
                div  = (div == 2) ? 0 : div + 1;
            end
            2: tick = 1'($urandom_range(0, 1));
            default: tick = 1'b0;
        endcase
    end

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", int'(state_o), int'(s));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seq[10];
        int n;
        seq = '{0, 0, 0, 1, 2, 3, 3, 4, 5, 0};
        reset_n    = 1'b0;
        tick       = 1'b1;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state_o), 0);
        chk("rst_main", int'(main_lights), 3'b100);
        chk("rst_side", int'(side_lights), 3'b001);
        chk("rst_walk", int'(ped_walk), 0);
        chk("rst_pending", int'(ped_pending), 0);
        reset_n = 1'b1;

        // Full cycle with a tick on every clock
        for (int i = 0; i < 10; i++) begin
            chk("seq", int'(state_o), seq[i]);
            @(negedge clk);
        end

        // Single-cycle pedestrian pulse during RG
        wait_state(3'd3, 50);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("ped_latched", int'(ped_pending), 1);
        wait_state(3'd6, 50);
        chk("ped_walk_on", int'(ped_walk), 1);
        chk("ped_cleared", int'(ped_pending), 0);
        n = 0;
        while (state_o == 3'd6 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ped_len", n, 4);
        chk("after_ped", int'(state_o), 0);

        // Button held across the PED entry edge
        wait_state(3'd3, 50);
        ped_req = 1'b1;
        wait_state(3'd6, 50);
        chk("held_clear", int'(ped_pending), 0);
        @(negedge clk);
        ped_req = 1'b0;
        chk("held_in_ped", int'(ped_pending), 0);
        wait_state(3'd0, 50);
        @(negedge clk);
        chk("no_second_ped", int'(state_o), 0);
        chk("no_second_pend", int'(ped_pending), 0);

        // Tick every third cycle
        tick_mode = 1;
        wait_state(3'd2, 100);
        wait_state(3'd3, 100);
        n = 0;
        while (state_o == 3'd3 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("rg_len_div3", n, 6);
        n = 0;
        while (state_o == 3'd4 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ry_len_div3", n, 3);

        // Night flash with a request latched during it
        tick_mode = 0;
        wait_state(3'd0, 100);
        flash_mode = 1'b1;
        wait_state(3'd7, 50);
        chk("flash_main_on", int'(main_lights), 3'b010);
        chk("flash_side_on", int'(side_lights), 3'b001);
        @(negedge clk);
        chk("flash_main_off", int'(main_lights), 3'b000);
        chk("flash_side_off", int'(side_lights), 3'b000);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("flash_pending", int'(ped_pending), 1);
        flash_mode = 1'b0;
        wait_state(3'd5, 10);
        @(negedge clk);
        chk("flash_to_ped", int'(state_o), 6);
        wait_state(3'd0, 20);

        // Asynchronous reset in the middle of RG
        wait_state(3'd3, 50);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", int'(state_o), 0);
        chk("arst_main", int'(main_lights), 3'b100);
        chk("arst_side", int'(side_lights), 3'b001);
        chk("arst_walk", int'(ped_walk), 0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (state_o == 3'd0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("gr_len_after_rst", n, 3);

        // Randomized traffic
        tick_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ped_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 149) == 0) flash_mode = !flash_mode;
            if ($urandom_range(0, 299) == 0) tick_mode = $urandom_range(0, 2);
        end
        flash_mode = 1'b0;
        ped_req    = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
